uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data bits per frame.
REQ-002 SHALL have parameter F_PARITY, default 2'b00, 00 none / 01 even / 10 odd.
REQ-003 SHALL have parameter CLK_FREQ, default 100000000, system clock in Hz.
REQ-004 SHALL have parameter BAUD_RATE, default 115200, line rate.
REQ-005 SHALL have parameter OVERSAMPLE, default 16, samples per bit.
REQ-006 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-007 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port i_rx, input, 1, serial line, idle high, asynchronous to clk.
REQ-009 SHALL have port i_ack, input, 1, consumer has taken o_data.
REQ-010 SHALL have port o_data, output, NB_DATA, last received word.
REQ-011 SHALL have port o_valid, output, 1, o_data holds an unacknowledged word.
REQ-012 SHALL have port o_busy, output, 1, frame in progress (state != IDLE).
REQ-013 SHALL have port o_frame_err, output, 1, stop bit sampled low on last frame.
REQ-014 SHALL have port o_parity_err, output, 1, parity mismatch on last frame (0 when F_PARITY=00).
REQ-015 SHALL have port o_overrun, output, 1, a frame completed while o_valid was high.

Function
REQ-016 SHALL pass i_rx through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-017 SHALL derive a sample tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer division, minimum 1).
REQ-018 SHALL hold the tick divider at zero in IDLE and restart it on the clock the falling edge is detected.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when F_PARITY=00.
REQ-020 IDLE -> START on synchronized falling edge of i_rx.
REQ-021 In START, at sample OVERSAMPLE/2, SHALL return to IDLE if line is high (glitch reject), else go to DATA.
REQ-022 In DATA, SHALL sample once per OVERSAMPLE ticks at mid-bit, LSB first, into a shift register; after NB_DATA bits go to PARITY or STOP.
REQ-023 In PARITY, SHALL sample the bit and compare with XOR of data (even) or its inverse (odd).
REQ-024 In STOP, at mid-bit, SHALL update o_data, o_frame_err (stop==0), o_parity_err, and return to IDLE on the same clock.
REQ-025 SHALL update o_data even on framing/parity error; errors are flags, not drops.
REQ-026 SHALL set o_valid on the STOP-sample clock; clear it on the clock after i_ack is seen high.
REQ-027 Simultaneous STOP completion and i_ack: o_valid SHALL stay 1 with new data; o_overrun SHALL not set.
REQ-028 Completion while o_valid=1 and no i_ack: SHALL set o_overrun sticky and overwrite o_data; o_overrun clears only with i_ack.
REQ-029 i_ack while o_valid=0 SHALL have no effect.
REQ-030 Latency: o_valid rises 2 synchronizer clocks plus (1.5+NB_DATA+P)·bit period after the start edge at i_rx (P=1 with parity).
REQ-031 SHALL accept a new start edge on the clock after returning to IDLE (back-to-back frames).

Reset
REQ-032 i_rst SHALL force state IDLE, divider/bit counters 0, synchronizer flops 1.
REQ-033 i_rst SHALL drive o_data=0, o_valid=0, o_busy=0, o_frame_err=0, o_parity_err=0, o_overrun=0.
REQ-034 Reset mid-frame SHALL discard the partial word; no o_valid after release until a full new frame.

Structure
REQ-035 Parity encoding constants (NONE/EVEN/ODD) and state encodings SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-036 Tick divider SHALL be sub-module uart_os_tick_gen (inputs clk, i_rst, i_clear; output o_tick).

Verification (bench: CLK_FREQ=7372800, BAUD_RATE=115200 -> DIV=4, 64 clocks/bit)
REQ-037 Frame 0xA5, no parity, stop=1 -> o_data=0xA5, o_valid=1, errors 0, o_busy low after stop sample.
REQ-038 F_PARITY=01, frame 0x07 with parity bit 0 -> o_parity_err=1, o_data=0x07.
REQ-039 0x3C with stop bit 0 -> o_frame_err=1, o_valid=1; next good frame clears o_frame_err.
REQ-040 i_rx low pulse of 20 clocks -> return to IDLE, no o_valid, o_busy back to 0.
REQ-041 Two back-to-back frames 0x11, 0x22 without i_ack -> o_data=0x22, o_overrun=1; i_ack clears o_valid and o_overrun.
REQ-042 i_rst asserted mid-DATA of 0xFF, then frame 0x55 -> only 0x55 reported.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity encodings, FSM states and divider helper
//
// Used by the receiver and the transmitter.
//   PAR_NONE / PAR_EVEN / PAR_ODD : 2-bit parity mode encodings
//   uart_state_t                  : frame FSM states
//   calc_div()                    : clocks per oversample tick, never below 1
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// rtl/uart_os_tick_gen.sv - oversample tick divider, held at zero while cleared
//
// Ports:
//   clk     : system clock
//   i_rst   : asynchronous active-high reset
//   i_clear : holds the divider at zero, no ticks while high
//   o_tick  : one-clock pulse every DIV clocks while not cleared
module uart_os_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = !i_clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity, framing and overrun flags
//
// Ports:
//   clk          : system clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_rx         : serial line, idle high, asynchronous to clk
//   i_ack        : consumer has taken o_data
//   o_data       : last received word (updated even on errors)
//   o_valid      : o_data holds an unacknowledged word
//   o_busy       : frame in progress
//   o_frame_err  : stop bit sampled low on last frame
//   o_parity_err : parity mismatch on last frame
//   o_overrun    : a frame completed while o_valid was high (sticky until i_ack)
module uart_rx
  import uart_pkg::*;
#(
  parameter int         NB_DATA    = 8,
  parameter logic [1:0] F_PARITY   = PAR_NONE,
  parameter int         CLK_FREQ   = 100000000,
  parameter int         BAUD_RATE  = 115200,
  parameter int         OVERSAMPLE = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_rx,
  input  logic               i_ack,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_overrun
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BC_W = $clog2(NB_DATA + 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'((OVERSAMPLE / 2 > 0) ? OVERSAMPLE / 2 - 1 : 0);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(NB_DATA - 1);

  uart_state_t state, state_nxt;

  logic               rx_meta, rx_sync, rx_prev;
  logic               tick;
  logic [OS_W-1:0]    os_cnt;
  logic [BC_W-1:0]    bit_cnt;
  logic [NB_DATA-1:0] shreg;
  logic               par_bit;
  logic               os_clr, shift_en, par_en, done;
  logic               data_par, exp_par, par_mismatch;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  // All reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Divider stays cleared through IDLE, including the edge-detect clock,
  // so the first tick lands DIV clocks after the frame is entered.
  uart_os_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_clear (state == ST_IDLE),
    .o_tick  (tick)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    os_clr    = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // Mid start bit: a high line means the edge was a glitch.
        if (tick && (os_cnt == HALF_LAST)) begin
          os_clr    = 1'b1;
          state_nxt = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && (os_cnt == OS_LAST)) begin
          os_clr   = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = (F_PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (tick && (os_cnt == OS_LAST)) begin
          os_clr    = 1'b1;
          par_en    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && (os_cnt == OS_LAST)) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (os_clr || (state == ST_IDLE)) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + 1'b1;
      end

      if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // LSB arrives first: shift in at the top, it ends up in bit 0.
      if (shift_en) begin
        shreg <= {rx_sync, shreg[NB_DATA-1:1]};
      end

      if (par_en) begin
        par_bit <= rx_sync;
      end
    end
  end

  assign data_par     = ^shreg;
  assign exp_par      = (F_PARITY == PAR_ODD) ? ~data_par : data_par;
  assign par_mismatch = (F_PARITY != PAR_NONE) && (par_bit != exp_par);

  // Completion wins over a same-clock ack for o_valid; the ack still
  // clears o_overrun, and overrun only sets when nobody acknowledged.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (done) begin
      o_data       <= shreg;
      o_frame_err  <= ~rx_sync;
      o_parity_err <= par_mismatch;
      o_valid      <= 1'b1;
      if (o_valid && !i_ack) begin
        o_overrun <= 1'b1;
      end else if (i_ack) begin
        o_overrun <= 1'b0;
      end
    end else if (i_ack && o_valid) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule
